// File: rtl/status_led_pkg.sv
// status_led_pkg
//   Shared types and default timing for the status LED scheduler.
//   state_t       : sequencer states (idle, pulse on, pulse off, gap, finish)
//   TON_DEF       : default ticks the LED stays lit per pulse
//   TOFF_DEF      : default ticks the LED stays dark between pulses
//   TGAP_DEF      : default ticks of trailing gap (also solid-on length for code 0)
package status_led_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ON   = 3'd1,
        S_OFF  = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam int TON_DEF  = 2;
    localparam int TOFF_DEF = 2;
    localparam int TGAP_DEF = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
//   Free-running prescaler; produces a one-cycle tick every 2**DIVW clocks.
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset (counter cleared)
//   tick     out high for one cycle when the counter is all ones
module led_tick_gen #(
    parameter int DIVW = 10
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    logic [DIVW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIVW'(1);
        end
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/status_led_sched.sv
// status_led_sched
//   Shares one user LED between NREQ status requesters. A fixed-priority
//   arbiter (index 0 highest) picks an owner; the owner's code N is shown as
//   N pulses followed by a dark gap. Code 0 is shown as a solid-on period
//   followed by the gap. The owner keeps the LED for the whole sequence.
//
//   Handshake: req[i] is a level request. Once granted, the sequence always
//   runs to completion; done[i] pulses for one cycle at the end, and grant
//   drops in that same cycle. The requester may deassert req[i] on seeing
//   done[i]; if req[i] is still high, the sequence repeats after one idle cycle.
//
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   req       in  [NREQ]       level requests
//   code      in  [NREQ*CNTW]  code[i*CNTW +: CNTW] = pulse count for req i
//   grant     out [NREQ]       one-hot owner, zero when idle/finishing
//   done      out [NREQ]       one-cycle end-of-sequence pulse for the owner
//   busy      out              sequence in progress
//   ULED      out              LED drive, 1 = lit
//   state_dbg out              current sequencer state
module status_led_sched
    import status_led_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DIVW = 10,
    parameter int CNTW = 3,
    parameter int TON  = TON_DEF,
    parameter int TOFF = TOFF_DEF,
    parameter int TGAP = TGAP_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CNTW-1:0] code,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 ULED,
    output state_t               state_dbg
);

    localparam int TMAX = max3(TON, TOFF, TGAP);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic            tick;
    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CNTW-1:0] pulse_q, pulse_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            req_any;
    logic [OW-1:0]   req_idx;
    logic [NREQ-1:0] grant_d, done_d;
    logic            busy_d, uled_d;
    logic [NREQ-1:0] grant_q, done_q;
    logic            busy_q, uled_q;

    led_tick_gen #(.DIVW(DIVW)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Fixed priority: scan from the top so the lowest set index wins.
    always_comb begin
        req_any = |req;
        req_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) req_idx = OW'(i);
        end
    end

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            pulse_q <= '0;
            tcnt_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            uled_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pulse_q <= pulse_d;
            tcnt_q  <= tcnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            uled_q  <= uled_d;
        end
    end

    // Next-state logic. Each timed state leaves on the tick that completes
    // its tick count, so every state after the first ON is tick-aligned.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        pulse_d = pulse_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_ON;
                    owner_d = req_idx;
                    // Code is captured once; later changes are ignored.
                    pulse_d = code[req_idx*CNTW +: CNTW];
                end
            end
            S_ON: begin
                if (tick) begin
                    if (pulse_q == '0) begin
                        if (tcnt_q == TW'(TGAP - 1)) state_d = S_GAP;
                    end else if (tcnt_q == TW'(TON - 1)) begin
                        state_d = S_OFF;
                    end
                end
            end
            S_OFF: begin
                if (tick && (tcnt_q == TW'(TOFF - 1))) begin
                    pulse_d = pulse_q - CNTW'(1);
                    state_d = (pulse_q == CNTW'(1)) ? S_GAP : S_ON;
                end
            end
            S_GAP: begin
                if (tick && (tcnt_q == TW'(TGAP - 1))) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Tick timer restarts on every state change and never runs in IDLE/FIN.
        tcnt_d = tcnt_q;
        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_FIN)) begin
            tcnt_d = '0;
        end else if (tick) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Output decode from the next state so the outputs register in step
    // with the state they describe.
    always_comb begin
        grant_d = '0;
        done_d  = '0;
        busy_d  = (state_d != S_IDLE);
        uled_d  = (state_d == S_ON);
        if ((state_d == S_ON) || (state_d == S_OFF) || (state_d == S_GAP)) begin
            grant_d = NREQ'(1) << owner_d;
        end
        if (state_d == S_FIN) begin
            done_d = NREQ'(1) << owner_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign ULED      = uled_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_status_led_sched.sv
// Directed bench for status_led_sched with a 4-cycle prescaler period.
module tb_status_led_sched;
    import status_led_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [11:0] code;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic        uled;
    state_t      state_dbg;

    int checks;
    int errors;

    status_led_sched #(
        .NREQ(4), .DIVW(2), .CNTW(3), .TON(2), .TOFF(2), .TGAP(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .code      (code),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .ULED      (uled),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo) && (obs <= hi)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_code(input int idx, input int val);
        code[idx*3 +: 3] = val[2:0];
    endtask

    // Waits for grant to the given requester, then watches ULED until done.
    // Optionally injects extra requests and a new code2 at monitored cycle inj_at.
    task automatic run_seq(input int idx, input int budget, input int inj_at,
                           input logic [3:0] inj_req, input int inj_code2,
                           output int wait_n, output int pre_hi, output int pulses,
                           output int hi_min, output int hi_max, output int tail,
                           output int bad_grant, output bit fin);
        logic [3:0] exp_g;
        int hi_run;
        int lo_run;
        exp_g     = 4'b0001 << idx;
        wait_n    = 0;
        pre_hi    = 0;
        pulses    = 0;
        hi_min    = 1000;
        hi_max    = 0;
        tail      = 0;
        bad_grant = 0;
        fin       = 1'b0;
        hi_run    = 0;
        lo_run    = 0;
        while ((grant !== exp_g) && (wait_n < 20)) begin
            if (uled === 1'b1) pre_hi++;
            @(negedge clk);
            wait_n++;
        end
        if (grant !== exp_g) return;
        for (int n = 0; n < budget; n++) begin
            if (n == inj_at) begin
                req         = req | inj_req;
                code[6 +: 3] = inj_code2[2:0];
            end
            if (uled === 1'b1) begin
                hi_run++;
                lo_run = 0;
            end else begin
                if (hi_run > 0) begin
                    pulses++;
                    if (hi_run < hi_min) hi_min = hi_run;
                    if (hi_run > hi_max) hi_max = hi_run;
                    hi_run = 0;
                end
                lo_run++;
            end
            if (done !== 4'b0000) begin
                fin  = (done === exp_g);
                tail = lo_run;
                if (grant !== 4'b0000) bad_grant++;
                req[idx] = 1'b0;
                break;
            end
            if (grant !== exp_g) bad_grant++;
            @(negedge clk);
        end
    endtask

    // One cycle after done: done must have dropped and the LED be released.
    task automatic post_check(input string tag);
        @(negedge clk);
        chk({tag, "_done_single"}, 32'(done), 32'd0);
        chk({tag, "_grant_clr"}, 32'(grant), 32'd0);
    endtask

    // ---------------- scoreboard-style directed sequence ----------------
    int  wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant;
    bit  fin;
    bit  seen_hi;
    int  done_seen;
    int  lit_seen;

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        req     = 4'hF;
        code    = '0;
        set_code(0, 1);
        set_code(1, 3);
        set_code(2, 2);
        set_code(3, 0);

        // 1: reset holds everything idle even with all requests high
        repeat (4) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_uled", 32'(uled), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        reset_n = 1'b1;
        wait_n = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wait_n++;
            if (grant === 4'b0001) break;
        end
        chk("rel_grant", 32'(grant), 32'd1);
        chk("rel_busy", 32'(busy), 32'd1);
        req = 4'b0001;
        run_seq(0, 400, -1, 4'b0000, 0, wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant, fin);
        chk("t1_fin", 32'(fin), 32'd1);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk_rng("t1_hi", hi_min, 5, 8);
        chk("t1_tail", 32'(tail), 32'd41);
        post_check("t1");

        // 2: code 3 on req[1]
        repeat (3) @(negedge clk);
        req = 4'b0010;
        run_seq(1, 400, -1, 4'b0000, 0, wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant, fin);
        chk("t2_wait", 32'(wait_n), 32'd1);
        chk("t2_fin", 32'(fin), 32'd1);
        chk("t2_pulses", 32'(pulses), 32'd3);
        chk_rng("t2_hi_min", hi_min, 5, 8);
        chk("t2_hi_max", 32'(hi_max), 32'd8);
        chk("t2_tail", 32'(tail), 32'd41);
        chk("t2_grant_held", 32'(bad_grant), 32'd0);
        post_check("t2");

        // 3: req[2] and req[0] together; 0 first, then 2 with no stray pulse
        repeat (2) @(negedge clk);
        req = 4'b0101;
        run_seq(0, 400, -1, 4'b0000, 0, wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant, fin);
        chk("t3a_fin", 32'(fin), 32'd1);
        chk("t3a_pulses", 32'(pulses), 32'd1);
        chk("t3a_grant_held", 32'(bad_grant), 32'd0);
        post_check("t3a");
        run_seq(2, 400, -1, 4'b0000, 0, wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant, fin);
        chk("t3b_wait", 32'(wait_n), 32'd1);
        chk("t3b_pre_hi", 32'(pre_hi), 32'd0);
        chk("t3b_fin", 32'(fin), 32'd1);
        chk("t3b_pulses", 32'(pulses), 32'd2);
        chk("t3b_tail", 32'(tail), 32'd41);
        post_check("t3b");

        // 4: code 0 gives a solid-on period then the gap
        repeat (2) @(negedge clk);
        req = 4'b1000;
        run_seq(3, 400, -1, 4'b0000, 0, wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant, fin);
        chk("t4_fin", 32'(fin), 32'd1);
        chk("t4_pulses", 32'(pulses), 32'd1);
        chk_rng("t4_solid", hi_max, 29, 32);
        chk("t4_tail", 32'(tail), 32'd33);
        post_check("t4");

        // 5: higher priority arrives mid-sequence and code2 changes; no effect
        repeat (2) @(negedge clk);
        set_code(2, 2);
        req = 4'b0100;
        run_seq(2, 400, 10, 4'b0001, 6, wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant, fin);
        chk("t5a_fin", 32'(fin), 32'd1);
        chk("t5a_pulses", 32'(pulses), 32'd2);
        chk("t5a_no_preempt", 32'(bad_grant), 32'd0);
        post_check("t5a");
        run_seq(0, 400, -1, 4'b0000, 0, wait_n, pre_hi, pulses, hi_min, hi_max, tail, bad_grant, fin);
        chk("t5b_wait", 32'(wait_n), 32'd1);
        chk("t5b_fin", 32'(fin), 32'd1);
        chk("t5b_pulses", 32'(pulses), 32'd1);
        post_check("t5b");

        // 6: reset during OFF of a 5-pulse code aborts without done
        repeat (2) @(negedge clk);
        set_code(1, 5);
        req     = 4'b0010;
        seen_hi = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uled === 1'b1) seen_hi = 1'b1;
            if (seen_hi && (uled === 1'b0) && (grant === 4'b0010)) break;
        end
        chk("t6_in_off", 32'(state_dbg), 32'(S_OFF));
        reset_n = 1'b0;
        #1;
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_uled", 32'(uled), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        req       = 4'b0000;
        done_seen = 0;
        lit_seen  = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done !== 4'b0000) done_seen++;
            if (uled !== 1'b0) lit_seen++;
        end
        chk("t6_no_done", 32'(done_seen), 32'd0);
        chk("t6_dark", 32'(lit_seen), 32'd0);
        chk("t6_idle", 32'(state_dbg), 32'(S_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
